sysace_loader: RTL and testbench

//  CLK80-domain consumer of the SystemACE sync stage. Takes a bulk load request
//  (start LBA, sector count, destination word address). Splits it into SystemACE

---
 rtl/sysace_loader.sv | 208 ++++++++++++++++++++
 tb/tb_sysace_loader.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysace_loader.sv
// Bulk sector loader: splits a request into SystemACE commands and packs the 16-bit
// read stream into 32-bit memory writes. Optional checksum output: SYSACE_LOADER_CKSUM_EN.
module sysace_loader #(
  parameter int ADDR_W    = 20,
  parameter int MAX_CHUNK = 256
) (
  input  logic              CLK80,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [27:0]       req_lba,
  input  logic [15:0]       req_nsectors,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              ld_busy,
  output logic              ld_done,
  output logic [27:0]       sysace_mpulba_80,
  output logic [7:0]        sysace_nsectors_80,
  output logic              sysace_start_80,
  input  logic              sysace_busy_80,
  input  logic [15:0]       fifo_dout_80,
  input  logic              fifo_empty_80,
  output logic              rd_en_80,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
`ifdef SYSACE_LOADER_CKSUM_EN
  output logic [31:0]       cksum,
`endif
  input  logic              mem_ready
);
  localparam int          WPS           = 128;
  localparam int          HW_PER_SECTOR = 2 * WPS;
  localparam logic [16:0] MAX_CHUNK_L   = 17'(MAX_CHUNK);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_BUSY, S_STREAM, S_WAIT_IDLE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [27:0]         lba_q, lba_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [8:0]          chunk_q, chunk_d;
  logic [16:0]         hw_left_q, hw_left_d;
  logic                rd_pend_q, rd_pend_d;
  logic                half_q, half_d;
  logic [15:0]         lo_q, lo_d;
  logic [31:0]         word_q, word_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         rem_after;
  logic                wr_accept;
  logic                req_accept;

  function automatic logic [8:0] chunk_of(input logic [15:0] n);
    if ({1'b0, n} > MAX_CHUNK_L) chunk_of = MAX_CHUNK_L[8:0];
    else                         chunk_of = n[8:0];
  endfunction

  assign sysace_mpulba_80   = lba_q;
  assign sysace_nsectors_80 = chunk_q[7:0];
  assign mem_addr           = addr_q;
  assign mem_wdata          = word_q;
  assign mem_we             = we_q;
  assign wr_accept          = we_q && mem_ready;
  assign req_accept         = (state_q == S_IDLE) && req_valid;
  assign rem_after          = remaining_q - {7'd0, chunk_q};

  always_comb begin
    state_d         = state_q;
    lba_d           = lba_q;
    remaining_d     = remaining_q;
    chunk_d         = chunk_q;
    hw_left_d       = hw_left_q;
    rd_pend_d       = 1'b0;
    half_d          = half_q;
    lo_d            = lo_q;
    word_d          = word_q;
    we_d            = we_q;
    addr_d          = addr_q;
    req_ready       = (state_q == S_IDLE);
    ld_busy         = (state_q != S_IDLE);
    ld_done         = 1'b0;
    sysace_start_80 = 1'b0;
    rd_en_80        = 1'b0;

    if (wr_accept) begin
      we_d   = 1'b0;
      addr_d = addr_q + 1'b1;
    end
    // Returning halfword: first of a pair parks in lo_q, second completes the word.
    if (rd_pend_q) begin
      if (half_q) begin
        word_d = {fifo_dout_80, lo_q};
        we_d   = 1'b1;
        half_d = 1'b0;
      end else begin
        lo_d   = fifo_dout_80;
        half_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          remaining_d = req_nsectors;
          addr_d      = req_addr;
          half_d      = 1'b0;
          if (req_nsectors == 16'd0) begin
            state_d = S_DONE;
          end else begin
            lba_d   = req_lba;
            chunk_d = chunk_of(req_nsectors);
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (!sysace_busy_80) begin
          sysace_start_80 = 1'b1;
          state_d         = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (sysace_busy_80) begin
          hw_left_d = {8'd0, chunk_q} * 17'(HW_PER_SECTOR);
          state_d   = S_STREAM;
        end
      end
      S_STREAM: begin
        // Odd hw_left means the next read completes a word, so the word register
        // must be free (or leaving this cycle) by the time that halfword returns.
        rd_en_80 = !fifo_empty_80 && (hw_left_q != 17'd0) && !rd_pend_q &&
                   (!hw_left_q[0] || !we_q || mem_ready);
        if (rd_en_80) begin
          rd_pend_d = 1'b1;
          hw_left_d = hw_left_q - 17'd1;
        end
        if ((hw_left_q == 17'd0) && !rd_pend_q && (!we_q || mem_ready))
          state_d = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (!sysace_busy_80) begin
          remaining_d = rem_after;
          if (rem_after == 16'd0) begin
            state_d = S_DONE;
          end else begin
            lba_d   = lba_q + {19'd0, chunk_q};
            chunk_d = chunk_of(rem_after);
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        ld_done = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK80 or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lba_q       <= '0;
      remaining_q <= '0;
      chunk_q     <= '0;
      hw_left_q   <= '0;
      rd_pend_q   <= 1'b0;
      half_q      <= 1'b0;
      lo_q        <= '0;
      word_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      lba_q       <= lba_d;
      remaining_q <= remaining_d;
      chunk_q     <= chunk_d;
      hw_left_q   <= hw_left_d;
      rd_pend_q   <= rd_pend_d;
      half_q      <= half_d;
      lo_q        <= lo_d;
      word_q      <= word_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
    end
  end

`ifdef SYSACE_LOADER_CKSUM_EN
  logic [31:0] cksum_q, cksum_d;

  always_comb begin
    cksum_d = cksum_q;
    if (req_accept)     cksum_d = 32'd0;
    else if (wr_accept) cksum_d = cksum_q + word_q;
  end

  always_ff @(posedge CLK80 or posedge RST) begin
    if (RST) cksum_q <= 32'd0;
    else     cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`else
  logic unused_accept;
  assign unused_accept = req_accept;
`endif
endmodule

// File: tb/tb_sysace_loader.sv
// Bench for sysace_loader: SystemACE sync-stage/FIFO model feeding a write scoreboard.
// Instance a uses default parameters, instance b a small chunk and narrow address.
`timescale 1ns/1ps
module tb_sysace_loader;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sel;
  logic        req_valid;
  logic [27:0] req_lba;
  logic [15:0] req_nsectors;
  logic [19:0] req_addr;
  logic        busy_in, ext_busy, sy_busy;
  logic [15:0] fifo_dout;
  logic        fifo_empty, mem_ready;

  logic        a_req_ready, a_ld_busy, a_ld_done, a_start, a_rd_en, a_we;
  logic [27:0] a_lba;
  logic [7:0]  a_ns;
  logic [19:0] a_addr;
  logic [31:0] a_wdata;
  logic        b_req_ready, b_ld_busy, b_ld_done, b_start, b_rd_en, b_we;
  logic [27:0] b_lba;
  logic [7:0]  b_ns;
  logic [7:0]  b_addr;
  logic [31:0] b_wdata;
`ifdef SYSACE_LOADER_CKSUM_EN
  logic [31:0] a_cksum, b_cksum;
`endif

  sysace_loader dut_a (
    .CLK80(clk), .RST(rst),
    .req_valid(req_valid & ~sel), .req_ready(a_req_ready),
    .req_lba(req_lba), .req_nsectors(req_nsectors), .req_addr(req_addr),
    .ld_busy(a_ld_busy), .ld_done(a_ld_done),
    .sysace_mpulba_80(a_lba), .sysace_nsectors_80(a_ns), .sysace_start_80(a_start),
    .sysace_busy_80(busy_in & ~sel), .fifo_dout_80(fifo_dout),
    .fifo_empty_80(fifo_empty | sel), .rd_en_80(a_rd_en),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_we(a_we),
`ifdef SYSACE_LOADER_CKSUM_EN
    .cksum(a_cksum),
`endif
    .mem_ready(mem_ready & ~sel)
  );

  sysace_loader #(.ADDR_W(8), .MAX_CHUNK(3)) dut_b (
    .CLK80(clk), .RST(rst),
    .req_valid(req_valid & sel), .req_ready(b_req_ready),
    .req_lba(req_lba), .req_nsectors(req_nsectors), .req_addr(req_addr[7:0]),
    .ld_busy(b_ld_busy), .ld_done(b_ld_done),
    .sysace_mpulba_80(b_lba), .sysace_nsectors_80(b_ns), .sysace_start_80(b_start),
    .sysace_busy_80(busy_in & sel), .fifo_dout_80(fifo_dout),
    .fifo_empty_80(fifo_empty | ~sel), .rd_en_80(b_rd_en),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_we(b_we),
`ifdef SYSACE_LOADER_CKSUM_EN
    .cksum(b_cksum),
`endif
    .mem_ready(mem_ready & sel)
  );

  logic        m_req_ready, m_ld_busy, m_ld_done, m_start, m_rd_en, m_we;
  logic [27:0] m_lba;
  logic [7:0]  m_ns;
  logic [19:0] m_addr;
  logic [31:0] m_wdata;
  assign m_req_ready = sel ? b_req_ready : a_req_ready;
  assign m_ld_busy   = sel ? b_ld_busy   : a_ld_busy;
  assign m_ld_done   = sel ? b_ld_done   : a_ld_done;
  assign m_start     = sel ? b_start     : a_start;
  assign m_rd_en     = sel ? b_rd_en     : a_rd_en;
  assign m_we        = sel ? b_we        : a_we;
  assign m_lba       = sel ? b_lba       : a_lba;
  assign m_ns        = sel ? b_ns        : a_ns;
  assign m_addr      = sel ? {12'd0, b_addr} : a_addr;
  assign m_wdata     = sel ? b_wdata     : a_wdata;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [19:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [15:0] fq[$];
  logic [27:0] cmd_lba[$];
  logic [7:0]  cmd_ns[$];
  int          prod_left, sy_delay, tail, hw_cnt;
  int          writes_seen, done_cnt, rd_cnt;
  bit          pend, par, ones_mode, rand_ready, stall_prev;
  logic [15:0] pend_data, lo_hw;
  logic [19:0] exp_addr, stall_addr;
  logic [31:0] first_wdata, stall_data;

  task automatic produce_hw();
    logic [15:0] hw;
    wr_t w;
    hw = ones_mode ? 16'h0001 : hw_cnt[15:0];
    hw_cnt++;
    fq.push_back(hw);
    if (!par) begin
      lo_hw = hw;
      par   = 1'b1;
    end else begin
      w.addr = exp_addr & (sel ? 20'h000FF : 20'hFFFFF);
      w.data = {hw, lo_hw};
      exp_q.push_back(w);
      exp_addr = exp_addr + 20'd1;
      par      = 1'b0;
    end
  endtask

  // Environment: drive inputs on the falling edge, sample DUT outputs 1ns later.
  initial begin
    wr_t w;
    prod_left = 0; sy_delay = 0; tail = 0; pend = 0; par = 0; stall_prev = 0;
    sy_busy = 0; busy_in = 0; fifo_empty = 1; fifo_dout = '0; mem_ready = 1;
    forever begin
      @(negedge clk);
      mem_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (pend) begin
        fifo_dout = pend_data;
        pend      = 1'b0;
      end
      if (sy_delay > 0) begin
        sy_delay--;
        if (sy_delay == 0) sy_busy = 1'b1;
      end
      if (sy_busy && prod_left > 0) begin
        produce_hw();
        prod_left--;
      end else if (sy_busy && prod_left == 0 && fq.size() == 0) begin
        if (tail == 0) sy_busy = 1'b0;
        else tail--;
      end
      busy_in    = sy_busy | ext_busy;
      fifo_empty = (fq.size() == 0);
      #1;
      if (rst) begin
        fq.delete(); exp_q.delete();
        prod_left = 0; sy_delay = 0; sy_busy = 0; pend = 0; par = 0; stall_prev = 0;
      end else begin
        if (m_start) begin
          chk("start_while_busy", 64'(busy_in), 64'd0);
          cmd_lba.push_back(m_lba);
          cmd_ns.push_back(m_ns);
          prod_left = (m_ns == 8'd0) ? 65536 : int'(m_ns) * 256;
          sy_delay  = 2;
          tail      = 2;
        end
        if (m_rd_en) begin
          chk("rd_on_empty", 64'(fifo_empty), 64'd0);
          if (fq.size() > 0) pend_data = fq.pop_front();
          pend = 1'b1;
          rd_cnt++;
        end
        if (m_ld_done) done_cnt++;
        if (stall_prev) begin
          chk("hold_we", 64'(m_we), 64'd1);
          chk("hold_addr", 64'(m_addr), 64'(stall_addr));
          chk("hold_data", 64'(m_wdata), 64'(stall_data));
        end
        if (m_we && mem_ready) begin
          chk("write_expected", 64'(exp_q.size() > 0), 64'd1);
          if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("wr_addr", 64'(m_addr), 64'(w.addr));
            chk("wr_data", 64'(m_wdata), 64'(w.data));
          end
          if (writes_seen == 0) first_wdata = m_wdata;
          writes_seen++;
        end
        stall_prev = m_we && !mem_ready;
        stall_addr = m_addr;
        stall_data = m_wdata;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic new_test(input logic [19:0] base);
    exp_addr = base; par = 0; hw_cnt = 0;
    writes_seen = 0; done_cnt = 0; rd_cnt = 0;
    cmd_lba.delete(); cmd_ns.delete(); exp_q.delete();
  endtask

  task automatic issue(input logic [27:0] lba, input logic [15:0] ns, input logic [19:0] addr);
    @(negedge clk);
    req_valid = 1'b1; req_lba = lba; req_nsectors = ns; req_addr = addr;
    #2;
    chk("req_ready_at_issue", 64'(m_req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int limit);
    int n = 0;
    while (done_cnt == 0 && n < limit) begin
      @(negedge clk);
      #2;
      n++;
    end
    tick(3);
    chk(tag, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 64'(m_req_ready), 64'd1);
    chk({tag, "_ld_busy"},   64'(m_ld_busy), 64'd0);
    chk({tag, "_ld_done"},   64'(m_ld_done), 64'd0);
    chk({tag, "_start"},     64'(m_start), 64'd0);
    chk({tag, "_rd_en"},     64'(m_rd_en), 64'd0);
    chk({tag, "_mem_we"},    64'(m_we), 64'd0);
    chk({tag, "_lba"},       64'(m_lba), 64'd0);
    chk({tag, "_nsect"},     64'(m_ns), 64'd0);
    chk({tag, "_mem_addr"},  64'(m_addr), 64'd0);
    chk({tag, "_wdata"},     64'(m_wdata), 64'd0);
  endtask

  task automatic report(input string name);
    $display("txn %s writes=%0d cmds=%0d done=%0d", name, writes_seen, cmd_lba.size(), done_cnt);
  endtask

  initial begin
    int n;
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_lba = '0; req_nsectors = '0; req_addr = '0;
    ext_busy = 1'b0; ones_mode = 1'b0; rand_ready = 1'b0;
    writes_seen = 0; done_cnt = 0; rd_cnt = 0; hw_cnt = 0; exp_addr = '0;
    #2;
    check_reset_outputs("reset");
    tick(3);
    rst = 1'b0;
    tick(2);

    // 1 sector, with start held off by a busy sync stage and a request ignored mid-load
    new_test(20'h00100);
    ext_busy = 1'b1;
    issue(28'h0001234, 16'd1, 20'h00100);
    #2;
    chk("busy_after_accept", 64'(m_ld_busy), 64'd1);
    chk("ready_after_accept", 64'(m_req_ready), 64'd0);
    tick(6);
    chk("no_start_while_busy", 64'(cmd_lba.size()), 64'd0);
    ext_busy = 1'b0;
    tick(20);
    req_valid = 1'b1; req_nsectors = 16'd0;
    tick(3);
    req_valid = 1'b0;
    wait_done("t1_done", 2000);
    chk("t1_cmds", 64'(cmd_lba.size()), 64'd1);
    if (cmd_lba.size() > 0) begin
      chk("t1_lba", 64'(cmd_lba[0]), 64'h1234);
      chk("t1_nsect", 64'(cmd_ns[0]), 64'h01);
    end
    chk("t1_writes", 64'(writes_seen), 64'd128);
    chk("t1_first_wdata", 64'(first_wdata), 64'h00010000);
    chk("t1_last_addr", 64'(exp_addr), 64'h00180);
    chk("t1_leftover", 64'(exp_q.size()), 64'd0);
    report("1sect");

    // zero-sector request
    new_test(20'h00000);
    issue(28'h0000777, 16'd0, 20'h00040);
    #2;
    chk("t2_done_next_cycle", 64'(m_ld_done), 64'd1);
    tick(1);
    #2;
    chk("t2_done_one_cycle", 64'(m_ld_done), 64'd0);
    chk("t2_ready_again", 64'(m_req_ready), 64'd1);
    tick(5);
    chk("t2_done_cnt", 64'(done_cnt), 64'd1);
    chk("t2_no_start", 64'(cmd_lba.size()), 64'd0);
    chk("t2_no_rd_en", 64'(rd_cnt), 64'd0);
    report("0sect");

    // random backpressure with an address that wraps
    new_test(20'hFFFC0);
    rand_ready = 1'b1;
    issue(28'h0000055, 16'd1, 20'hFFFC0);
    wait_done("t3_done", 4000);
    rand_ready = 1'b0;
    chk("t3_writes", 64'(writes_seen), 64'd128);
    chk("t3_leftover", 64'(exp_q.size()), 64'd0);
    report("backpressure");

    // split over commands with lba/address wrap on the small instance
    tick(2);
    sel = 1'b1;
    tick(2);
    new_test(20'h000F0);
    issue(28'hFFFFFFE, 16'd7, 20'h000F0);
    wait_done("t4_done", 10000);
    chk("t4_cmds", 64'(cmd_lba.size()), 64'd3);
    if (cmd_lba.size() == 3) begin
      chk("t4_lba0", 64'(cmd_lba[0]), 64'hFFFFFFE);
      chk("t4_ns0",  64'(cmd_ns[0]), 64'd3);
      chk("t4_lba1", 64'(cmd_lba[1]), 64'h0000001);
      chk("t4_ns1",  64'(cmd_ns[1]), 64'd3);
      chk("t4_lba2", 64'(cmd_lba[2]), 64'h0000004);
      chk("t4_ns2",  64'(cmd_ns[2]), 64'd1);
    end
    chk("t4_writes", 64'(writes_seen), 64'd896);
    chk("t4_leftover", 64'(exp_q.size()), 64'd0);
    report("split");
    tick(2);
    sel = 1'b0;
    tick(2);

    // 300 sectors: full-size first command, then reset after 40 writes
    new_test(20'h00000);
    issue(28'h0000010, 16'd300, 20'h00000);
    n = 0;
    while (writes_seen < 40 && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("t5_reached_40", 64'(writes_seen >= 40), 64'd1);
    chk("t5_cmds", 64'(cmd_lba.size()), 64'd1);
    if (cmd_lba.size() > 0) begin
      chk("t5_lba0", 64'(cmd_lba[0]), 64'h10);
      chk("t5_ns0", 64'(cmd_ns[0]), 64'h00);
    end
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick(2);
    rst = 1'b0;
    tick(4);
    chk("t5_no_done", 64'(done_cnt), 64'd0);
    report("abort");

    new_test(20'h00200);
    issue(28'h0000020, 16'd1, 20'h00200);
    wait_done("t5b_done", 2000);
    chk("t5b_writes", 64'(writes_seen), 64'd128);
    if (cmd_lba.size() > 0) chk("t5b_lba", 64'(cmd_lba[0]), 64'h20);
    chk("t5b_leftover", 64'(exp_q.size()), 64'd0);
    report("after_reset");

    // all-ones halfwords
    new_test(20'h00300);
    ones_mode = 1'b1;
    issue(28'h0000100, 16'd1, 20'h00300);
    wait_done("t6_done", 2000);
    ones_mode = 1'b0;
    chk("t6_writes", 64'(writes_seen), 64'd128);
`ifdef SYSACE_LOADER_CKSUM_EN
    chk("t6_cksum", 64'(a_cksum), 64'h00800080);
`endif
    report("ones");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
